// File: rtl/lfsr_seq_ctrl_if.sv
// lfsr_seq_ctrl_if
//   Configuration write port of the LFSR sequencer. A write is accepted on
//   the rising clk edge where cfg_valid and cfg_ready are both high.
//   cfg_valid  master->slave  write request (held until accepted)
//   cfg_ready  slave->master  controller can take a write this cycle
//   cfg_addr   master->slave  0=SEED 1=TAPS 2=DIV 3=CTRL
//   cfg_wdata  master->slave  write data, W bits
interface lfsr_seq_ctrl_if #(
  parameter int W = 32
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic [1:0]   cfg_addr;
  logic [W-1:0] cfg_wdata;

  modport master (output cfg_valid, output cfg_addr, output cfg_wdata, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_wdata, output cfg_ready);
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl
//   Sequencer/configurator for a W-bit tapped Fibonacci LFSR. Holds seed, tap
//   mask, step divider and external-input injection control; loads, runs,
//   pauses and reseeds the shift register automatically on all-zero lockup.
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   cfg       if   configuration write port (slave side)
//   i_ext_in  in   8 asynchronous pin inputs, synchronised with two flops
//   o_data    out  shifter[7:0], registered
//   o_step    out  one-clk pulse for each cycle the shifter advanced
//   o_lockup  out  one-clk pulse while the reseed after a zero state runs
//   o_state   out  FSM state (0=IDLE 1=LOAD 2=RUN 3=RESEED)
//
// state  | meaning
// IDLE   | paused / stopped, shifter holds, waits for CTRL.RUN
// LOAD   | one clk: shifter <= seed, prescaler <= div
// RUN    | shifter advances on every prescaler terminal count
// RESEED | one clk after a zero result with injection off: shifter <= seed
module lfsr_seq_ctrl #(
  parameter int           W        = 32,
  parameter logic [W-1:0] INI      = 32'h0000_00AB,
  parameter logic [W-1:0] DEF_TAPS = 32'hA300_0000,
  parameter logic [W-1:0] DEF_DIV  = 32'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lfsr_seq_ctrl_if.slave       cfg,
  input  logic [7:0]           i_ext_in,
  output logic [7:0]           o_data,
  output logic                 o_step,
  output logic                 o_lockup,
  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESEED = 2'd3
  } state_t;

  localparam logic [W-1:0] ONE = 1;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_shifter;
  logic [W-1:0] r_seed;
  logic [W-1:0] r_taps;
  logic [W-1:0] r_div;
  logic [W-1:0] r_cnt;
  logic         r_run;
  logic         r_inj_en;
  logic [7:0]   r_inj_mask;
  logic [7:0]   r_sync1;
  logic [7:0]   r_sync2;
  logic         r_need_load;
  logic [7:0]   r_data;
  logic         r_step;
  logic         r_lockup;

  logic         w_wr;
  logic         w_wr_seed;
  logic         w_wr_taps;
  logic         w_wr_div;
  logic         w_wr_ctrl;
  logic         w_fb;
  logic [W-1:0] w_shift_val;
  logic [W-1:0] w_shifter_nxt;
  logic         w_step;
  logic         w_reload;
  logic         w_cnt_load;
  logic         w_cnt_dec;

  // Writes stall only during the single-cycle LOAD/RESEED states.
  assign cfg.cfg_ready = (r_state == ST_IDLE) || (r_state == ST_RUN);

  assign w_wr      = cfg.cfg_valid & cfg.cfg_ready;
  assign w_wr_seed = w_wr & (cfg.cfg_addr == 2'd0);
  assign w_wr_taps = w_wr & (cfg.cfg_addr == 2'd1);
  assign w_wr_div  = w_wr & (cfg.cfg_addr == 2'd2);
  assign w_wr_ctrl = w_wr & (cfg.cfg_addr == 2'd3);

  // Feedback uses the registered taps/mask, so a write on a step edge only
  // affects the following steps.
  assign w_fb        = (^(r_shifter & r_taps)) ^ (r_inj_en & (^(r_inj_mask & r_sync2)));
  assign w_shift_val = {r_shifter[W-2:0], w_fb};

  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_reload    = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Resume continues from the held value unless a new seed is pending.
        if (r_run) begin
          if (r_need_load) begin
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_RUN;
            w_cnt_load  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        w_reload    = 1'b1;
        w_cnt_load  = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!r_run) begin
          w_state_nxt = ST_IDLE;
        end else begin
          if (r_cnt == '0) begin
            w_step     = 1'b1;
            w_cnt_load = 1'b1;
          end else begin
            w_cnt_dec = 1'b1;
          end
          if (w_wr_seed) begin
            w_state_nxt = ST_LOAD;
          end else if (w_step && (w_shift_val == '0) && !r_inj_en) begin
            w_state_nxt = ST_RESEED;
          end
        end
      end
      ST_RESEED: begin
        w_reload    = 1'b1;
        w_cnt_load  = 1'b1;
        w_state_nxt = r_run ? ST_RUN : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_shifter_nxt = w_reload ? r_seed : (w_step ? w_shift_val : r_shifter);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shifter   <= INI;
      r_seed      <= INI;
      r_taps      <= DEF_TAPS;
      r_div       <= DEF_DIV;
      r_cnt       <= DEF_DIV;
      r_run       <= 1'b0;
      r_inj_en    <= 1'b0;
      r_inj_mask  <= 8'h00;
      r_sync1     <= 8'hFF;
      r_sync2     <= 8'hFF;
      r_need_load <= 1'b1;
      r_data      <= INI[7:0];
      r_step      <= 1'b0;
      r_lockup    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sync1   <= i_ext_in;
      r_sync2   <= r_sync1;
      r_shifter <= w_shifter_nxt;
      r_data    <= w_shifter_nxt[7:0];
      r_step    <= w_step;
      r_lockup  <= (w_state_nxt == ST_RESEED);

      if (w_wr_seed) r_seed <= (cfg.cfg_wdata == '0) ? INI : cfg.cfg_wdata;
      if (w_wr_taps) r_taps <= cfg.cfg_wdata;
      if (w_wr_div)  r_div  <= cfg.cfg_wdata;
      if (w_wr_ctrl) begin
        r_run      <= cfg.cfg_wdata[0];
        r_inj_en   <= cfg.cfg_wdata[1];
        r_inj_mask <= cfg.cfg_wdata[15:8];
      end

      // A DIV write restarts the spacing from the new value immediately.
      if (w_wr_div)        r_cnt <= cfg.cfg_wdata;
      else if (w_cnt_load) r_cnt <= r_div;
      else if (w_cnt_dec)  r_cnt <= r_cnt - ONE;

      // Reset leaves this set so the first run after reset always loads.
      if (r_state == ST_LOAD) r_need_load <= 1'b0;
      else if (w_wr_seed)     r_need_load <= 1'b1;
    end
  end

  assign o_data   = r_data;
  assign o_step   = r_step;
  assign o_lockup = r_lockup;
  assign o_state  = r_state;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
module tb_lfsr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ext_in;
  logic [7:0] o_data;
  logic       o_step;
  logic       o_lockup;
  logic [1:0] o_state;

  lfsr_seq_ctrl_if #(.W(32)) cfg_if ();

  lfsr_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg      (cfg_if),
    .i_ext_in (ext_in),
    .o_data   (o_data),
    .o_step   (o_step),
    .o_lockup (o_lockup),
    .o_state  (o_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int step_cnt = 0;
  int lock_cnt = 0;
  int lock_cyc = 0;
  int wr_cyc = 0;
  int step_at [4096];
  logic [7:0] exp_q [$];

  int w, w2, base, lbase;
  logic [31:0] s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lfsr_nx(input logic [31:0] st, input logic [31:0] taps,
                                          input logic inj);
    return {st[30:0], (^(st & taps)) ^ inj};
  endfunction

  // Scoreboard: every step pops the next expected data byte.
  always @(negedge clk) begin
    if (o_step === 1'b1) begin
      if (step_cnt + 1 < 4096) step_at[step_cnt+1] = cyc;
      step_cnt++;
      if (exp_q.size() > 0) chk("step_data", {24'h0, o_data}, {24'h0, exp_q.pop_front()});
    end
    if (o_lockup === 1'b1) begin
      lock_cnt++;
      lock_cyc = cyc;
    end
  end

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    int k = 0;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = a;
    cfg_if.cfg_wdata = d;
    while (!cfg_if.cfg_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!cfg_if.cfg_ready) begin
      chk("wr_ready", {31'h0, cfg_if.cfg_ready}, 32'h1);
      cfg_if.cfg_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      wr_cyc = cyc;
      cfg_if.cfg_valid = 1'b0;
    end
  endtask

  task automatic wait_steps(input int target, input int budget);
    int k = 0;
    while (step_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (step_cnt < target) chk("step_timeout", step_cnt, target);
  endtask

  task automatic pause_run();
    int k = 0;
    cfg_wr(2'd3, 32'h0);
    while (o_state != 2'd0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (o_state != 2'd0) chk("pause_idle", {30'h0, o_state}, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"},   {24'h0, o_data}, 32'hAB);
    chk({tag, "_state"},  {30'h0, o_state}, 32'h0);
    chk({tag, "_step"},   {31'h0, o_step}, 32'h0);
    chk({tag, "_lockup"}, {31'h0, o_lockup}, 32'h0);
    chk({tag, "_ready"},  {31'h0, cfg_if.cfg_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ext_in = 8'hFF;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_addr  = 2'd0;
    cfg_if.cfg_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("t0_rst");
    rst_n = 1'b1;

    // T1: DIV=0, RUN -> LOAD then RUN, one step per clk
    cfg_wr(2'd2, 32'd0);
    s = 32'hAB;
    for (int i = 0; i < 8; i++) begin
      s = lfsr_nx(s, 32'hA300_0000, 1'b0);
      exp_q.push_back(s[7:0]);
    end
    base = step_cnt;
    cfg_wr(2'd3, 32'h1);
    w = wr_cyc;
    @(negedge clk); chk("t1_idle", {30'h0, o_state}, 32'd0);
    @(negedge clk); chk("t1_load", {30'h0, o_state}, 32'd1);
    chk("t1_load_ready", {31'h0, cfg_if.cfg_ready}, 32'h0);
    @(negedge clk); chk("t1_run", {30'h0, o_state}, 32'd2);
    wait_steps(base + 8, 40);
    chk("t1_first_step", step_at[base+1], w + 3);
    chk("t1_eighth_step", step_at[base+8], w + 10);
    chk("t1_queue", exp_q.size(), 0);
    pause_run();
    base = step_cnt;
    repeat (5) @(negedge clk);
    chk("t1_idle_nostep", step_cnt - base, 0);

    // T2: DIV=5 spacing, then DIV write mid-count
    cfg_wr(2'd0, 32'h1234_5678);
    cfg_wr(2'd2, 32'd5);
    s = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      s = lfsr_nx(s, 32'hA300_0000, 1'b0);
      exp_q.push_back(s[7:0]);
    end
    base = step_cnt;
    cfg_wr(2'd3, 32'h1);
    w = wr_cyc;
    wait_steps(base + 3, 60);
    chk("t2_first_step", step_at[base+1], w + 8);
    chk("t2_gap1", step_at[base+2] - step_at[base+1], 6);
    chk("t2_gap2", step_at[base+3] - step_at[base+2], 6);
    cfg_wr(2'd2, 32'd2);
    w2 = wr_cyc;
    wait_steps(base + 5, 40);
    chk("t2_div_restart", step_at[base+4], w2 + 3);
    chk("t2_new_gap", step_at[base+5] - step_at[base+4], 3);
    chk("t2_queue", exp_q.size(), 0);
    pause_run();

    // T3: zero seed maps to INI; resume without reload; SEED write while running
    cfg_wr(2'd0, 32'h0);
    cfg_wr(2'd3, 32'h1);
    @(negedge clk);
    @(negedge clk); chk("t3_load", {30'h0, o_state}, 32'd1);
    @(negedge clk); chk("t3_zero_seed_data", {24'h0, o_data}, 32'hAB);
    chk("t3_run", {30'h0, o_state}, 32'd2);
    pause_run();
    cfg_wr(2'd3, 32'h1);
    @(negedge clk);
    @(negedge clk); chk("t3_resume_noload", {30'h0, o_state}, 32'd2);
    cfg_wr(2'd0, 32'hCAFE_0001);
    @(negedge clk); chk("t3_seed_run_load", {30'h0, o_state}, 32'd1);
    @(negedge clk); chk("t3_seed_run_data", {24'h0, o_data}, 32'h01);
    chk("t3_seed_run_back", {30'h0, o_state}, 32'd2);
    pause_run();

    // T4: taps=0 drains to zero, lockup/reseed, write held over RESEED
    cfg_wr(2'd1, 32'h0);
    cfg_wr(2'd2, 32'd0);
    cfg_wr(2'd0, 32'h1);
    s = 32'h1;
    for (int i = 0; i < 32; i++) begin
      s = lfsr_nx(s, 32'h0, 1'b0);
      exp_q.push_back(s[7:0]);
    end
    s = 32'h1;
    for (int i = 0; i < 2; i++) begin
      s = lfsr_nx(s, 32'h0, 1'b0);
      exp_q.push_back(s[7:0]);
    end
    lbase = lock_cnt;
    base = step_cnt;
    cfg_wr(2'd3, 32'h1);
    w = wr_cyc;
    for (int k = 0; k < 100 && cyc < w + 34; k++) begin
      @(posedge clk);
      #1;
    end
    chk("t4_reseed_state", {30'h0, o_state}, 32'd3);
    chk("t4_lockup", {31'h0, o_lockup}, 32'h1);
    chk("t4_reseed_ready", {31'h0, cfg_if.cfg_ready}, 32'h0);
    cfg_wr(2'd2, 32'd3);
    chk("t4_held_write", wr_cyc, w + 36);
    wait_steps(base + 34, 60);
    chk("t4_lock_cycle", lock_cyc, w + 34);
    chk("t4_zero_step", step_at[base+32], w + 34);
    chk("t4_resume_step", step_at[base+33], w + 36);
    chk("t4_after_div", step_at[base+34], w + 40);
    chk("t4_queue", exp_q.size(), 0);
    pause_run();
    chk("t4_lock_once", lock_cnt - lbase, 1);

    // T5: injection from ext_in[0], zero state legal with INJ_EN=1
    ext_in = 8'hFE;
    cfg_wr(2'd1, 32'h0);
    cfg_wr(2'd2, 32'd0);
    cfg_wr(2'd0, 32'h1);
    s = 32'h1;
    for (int i = 0; i < 40; i++) begin
      s = lfsr_nx(s, 32'h0, 1'b0);
      exp_q.push_back(s[7:0]);
    end
    lbase = lock_cnt;
    base = step_cnt;
    cfg_wr(2'd3, 32'h0000_0103);
    w = wr_cyc;
    for (int k = 0; k < 100 && cyc < w + 42; k++) @(negedge clk);
    ext_in = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      s = lfsr_nx(s, 32'h0, (i >= 2));
      exp_q.push_back(s[7:0]);
    end
    wait_steps(base + 45, 80);
    chk("t5_last_step", step_at[base+45], w + 47);
    chk("t5_queue", exp_q.size(), 0);
    chk("t5_no_lockup", lock_cnt - lbase, 0);
    chk("t5_still_run", {30'h0, o_state}, 32'd2);
    pause_run();

    // T6a: reset asserted during LOAD
    cfg_wr(2'd0, 32'h5555_AAAA);
    cfg_wr(2'd3, 32'h1);
    for (int k = 0; k < 10 && o_state != 2'd1; k++) @(negedge clk);
    chk("t6_in_load", {30'h0, o_state}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst_load");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_ctrl_cleared", {30'h0, o_state}, 32'd0);
    s = 32'hAB;
    for (int i = 0; i < 3; i++) begin
      s = lfsr_nx(s, 32'hA300_0000, 1'b0);
      exp_q.push_back(s[7:0]);
    end
    base = step_cnt;
    cfg_wr(2'd3, 32'h1);
    w = wr_cyc;
    wait_steps(base + 3, 30);
    chk("t6_reload_first_step", step_at[base+1], w + 3);
    chk("t6_queue_a", exp_q.size(), 0);

    // T6b: reset asserted mid-prescale
    cfg_wr(2'd2, 32'd7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst_prescale");
    @(negedge clk);
    rst_n = 1'b1;

    // T6c: write presented during LOAD waits for ready, then lands
    cfg_wr(2'd2, 32'd9);
    cfg_wr(2'd0, 32'h0000_0F0F);
    s = lfsr_nx(32'h0000_0F0F, 32'hA300_0000, 1'b0);
    exp_q.push_back(s[7:0]);
    base = step_cnt;
    cfg_wr(2'd3, 32'h1);
    w = wr_cyc;
    for (int k = 0; k < 10 && o_state != 2'd1; k++) begin
      @(posedge clk);
      #1;
    end
    chk("t6_load_not_ready", {31'h0, cfg_if.cfg_ready}, 32'h0);
    cfg_wr(2'd2, 32'd4);
    chk("t6_held_write", wr_cyc, w + 3);
    wait_steps(base + 1, 30);
    chk("t6_held_div_step", step_at[base+1], w + 8);
    chk("t6_queue_c", exp_q.size(), 0);
    pause_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
